// File: rtl/control_unit.sv
// Purpose : multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving ALU, accumulator and output-register strobes.
// Latency : ALU ops take 4 cycles plus one per cycle alu_busy holds EXECUTE; OUTPUT/JMP/JZ/NOP take 3 cycles; HALT is absorbing.
// Backpressure: alu_busy stalls only the EXECUTE state; every other state advances unconditionally.
module control_unit #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instruction,
    input  logic                alu_busy,
    input  logic                acc_zero,
    output logic [PC_WIDTH-1:0] program_counter,
    output logic [2:0]          alu_op,
    output logic [3:0]          operand_addr,
    output logic                acc_write_enable,
    output logic                out_write_enable,
    output logic [3:0]          out_index,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_OUT  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JZ   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;

    logic [3:0]          opcode;
    logic                is_alu;
    logic                is_out;
    logic [2:0]          alu_sel;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jump_target;
    logic                unused_ir_bits;

    // Everything downstream decodes from the captured word, never the live bus.
    assign opcode         = ir_q[15:12];
    assign pc_inc         = pc_q + PC_WIDTH'(1);
    assign jump_target    = PC_WIDTH'(ir_q[3:0]);
    assign unused_ir_bits = ^ir_q[7:4];

    // Opcode classification; non-ALU opcodes leave alu_op at 0.
    always_comb begin
        is_alu  = 1'b0;
        is_out  = 1'b0;
        alu_sel = 3'd0;
        case (opcode)
            OP_ADD: begin is_alu = 1'b1; alu_sel = 3'd0; end
            OP_SUB: begin is_alu = 1'b1; alu_sel = 3'd1; end
            OP_MUL: begin is_alu = 1'b1; alu_sel = 3'd2; end
            OP_DIV: begin is_alu = 1'b1; alu_sel = 3'd3; end
            OP_OUT: is_out = 1'b1;
            default: ;
        endcase
    end

    // State, program counter and instruction register; reset clears all of them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, PC update and writeback strobes.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        ir_d             = ir_q;
        acc_write_enable = 1'b0;
        out_write_enable = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_alu) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_EXECUTE: begin
                if (!alu_busy) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                acc_write_enable = is_alu;
                out_write_enable = is_out;
                state_d          = S_FETCH;
                if (opcode == OP_JMP) begin
                    pc_d = jump_target;
                end else if (opcode == OP_JZ && acc_zero) begin
                    pc_d = jump_target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign program_counter = pc_q;
    assign alu_op          = alu_sel;
    assign operand_addr    = ir_q[11:8];
    assign out_index       = ir_q[3:0];
    assign halted          = (state_q == S_HALT);

endmodule
